// File: rtl/design_select_sequencer.sv
// Parametrised design selector: synchronises design_select, hands the shared GPIO pads between
// user designs through a guarded DRAIN interval. Optional macro DESIGN_SEL_LOCK_EN adds sel_lock.
module design_select_sequencer #(
    parameter int NUM_DESIGNS  = 12,
    parameter int GPIO_W       = 34,
    parameter int SEL_W        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef DESIGN_SEL_LOCK_EN
    input  logic                          sel_lock,
`endif
    input  logic [SEL_W-1:0]              design_select,
    input  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_out,
    input  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_oeb,
    output logic [NUM_DESIGNS-1:0]        designs_ncs,
    output logic [GPIO_W-1:0]             gpio_out,
    output logic [GPIO_W-1:0]             gpio_oeb,
    output logic [SEL_W-1:0]              active_design,
    output logic                          switching
);

    localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(NUM_DESIGNS);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [SEL_W-1:0]       sync_q [SYNC_STAGES];
    logic [SEL_W-1:0]       sync_d [SYNC_STAGES];
    logic [SEL_W-1:0]       sel_s;
    logic [SEL_W-1:0]       sel_v;
    logic [SEL_W-1:0]       sel_prev_q, sel_prev_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0]       active_q, active_d;
    logic [NUM_DESIGNS-1:0] ncs_q, ncs_d;
    logic [GPIO_W-1:0]      out_q, out_d;
    logic [GPIO_W-1:0]      oeb_q, oeb_d;
    logic [GPIO_W-1:0]      slice_out, slice_oeb;
    logic                   lock_hold;

`ifdef DESIGN_SEL_LOCK_EN
    assign lock_hold = sel_lock;
`else
    assign lock_hold = 1'b0;
`endif

    function automatic logic [NUM_DESIGNS-1:0] ncs_for(input logic [SEL_W-1:0] code);
        logic [NUM_DESIGNS-1:0] r;
        r = '1;
        for (int d = 0; d < NUM_DESIGNS; d++) begin
            if (code == SEL_W'(d + 1)) r[d] = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_d[i] = (i == 0) ? design_select : sync_q[(i > 0) ? i - 1 : 0];
        end
    end

    assign sel_s = sync_q[SYNC_STAGES-1];
    assign sel_v = (sel_s != '0 && sel_s <= MAX_SEL) ? sel_s : '0;

    always_comb begin
        slice_out = '0;
        slice_oeb = '1;
        for (int d = 0; d < NUM_DESIGNS; d++) begin
            if (active_q == SEL_W'(d + 1)) begin
                slice_out = designs_gpio_out[d*GPIO_W +: GPIO_W];
                slice_oeb = designs_gpio_oeb[d*GPIO_W +: GPIO_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        ncs_d      = ncs_q;
        out_d      = out_q;
        oeb_d      = oeb_q;
        sel_prev_d = sel_v;
        case (state_q)
            ST_OFF: begin
                ncs_d = '1;
                out_d = '0;
                oeb_d = '1;
                if (sel_v != '0) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DRAIN: begin
                ncs_d = '1;
                out_d = '0;
                oeb_d = '1;
                // Any change of the validated select restarts the guard interval.
                if (sel_v != sel_prev_q) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    active_d = sel_v;
                    if (sel_v != '0) begin
                        state_d = ST_ACTIVE;
                        ncs_d   = ncs_for(sel_v);
                    end else begin
                        state_d = ST_OFF;
                    end
                end
            end
            ST_ACTIVE: begin
                out_d = slice_out;
                oeb_d = slice_oeb;
                // Leaving ACTIVE drops ncs and tristates the pads on the same edge.
                if (sel_v != active_q && !lock_hold) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                    ncs_d   = '1;
                    out_d   = '0;
                    oeb_d   = '1;
                end
            end
            default: begin
                state_d  = ST_OFF;
                cnt_d    = '0;
                active_d = '0;
                ncs_d    = '1;
                out_d    = '0;
                oeb_d    = '1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sel_prev_q <= '0;
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            active_q   <= '0;
            ncs_q      <= '1;
            out_q      <= '0;
            oeb_q      <= '1;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            sel_prev_q <= sel_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            ncs_q      <= ncs_d;
            out_q      <= out_d;
            oeb_q      <= oeb_d;
        end
    end

    assign designs_ncs   = ncs_q;
    assign gpio_out      = out_q;
    assign gpio_oeb      = oeb_q;
    assign active_design = active_q;
    assign switching     = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_design_select_sequencer.sv
// Bench for design_select_sequencer: directed hand-over scenarios plus random select traffic,
// compared every cycle against a window-based reference of the selection rules.
module tb_design_select_sequencer;

    localparam int N  = 12;
    localparam int GW = 34;
    localparam int SW = 4;
    localparam int S  = 2;
    localparam int G  = 4;
    localparam int NMAX = 8192;

    localparam int M_OFF = 0, M_DRAIN = 1, M_ACT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sel_lock = 1'b0;
    logic [SW-1:0]   design_select = '0;
    logic [N*GW-1:0] dg_out = '0;
    logic [N*GW-1:0] dg_oeb = '1;
    logic [N-1:0]    designs_ncs;
    logic [GW-1:0]   gpio_out, gpio_oeb;
    logic [SW-1:0]   active_design;
    logic            switching;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int            n = 0;
    int            first_edge = 1;
    int            selh [NMAX];
    int            mode = M_OFF;
    int            act = 0;
    int            dstart = 0;
    logic [N-1:0]  e_ncs = '1;
    logic [GW-1:0] e_out = '0;
    logic [GW-1:0] e_oeb = '1;

    design_select_sequencer #(
        .NUM_DESIGNS(N), .GPIO_W(GW), .SEL_W(SW), .SYNC_STAGES(S), .GUARD_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef DESIGN_SEL_LOCK_EN
        .sel_lock(sel_lock),
`endif
        .design_select(design_select),
        .designs_gpio_out(dg_out),
        .designs_gpio_oeb(dg_oeb),
        .designs_ncs(designs_ncs),
        .gpio_out(gpio_out),
        .gpio_oeb(gpio_oeb),
        .active_design(active_design),
        .switching(switching)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Validated, synchronised select as seen by the sequencer at edge k.
    function automatic int vsel(input int k);
        int s;
        if (k - S < first_edge) return 0;
        s = selh[k - S];
        return (s >= 1 && s <= N) ? s : 0;
    endfunction

    // A guard interval ends at edge e once the select held one value over edges e-G..e.
    function automatic bit window_stable(input int e);
        for (int k = e - G; k < e; k++) begin
            if (vsel(k) != vsel(e)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [GW-1:0] slice(input logic [N*GW-1:0] v, input int d);
        return v[(d-1)*GW +: GW];
    endfunction

    task automatic model_reset();
        mode = M_OFF;
        act = 0;
        e_ncs = '1;
        e_out = '0;
        e_oeb = '1;
        first_edge = n + 1;
    endtask

    task automatic model_step();
        int v;
        int prev;
        bit lk;
        v = vsel(n);
        prev = mode;
        lk = sel_lock;
`ifndef DESIGN_SEL_LOCK_EN
        lk = 1'b0;
`endif
        case (mode)
            M_OFF: if (v != 0) begin mode = M_DRAIN; dstart = n; end
            M_DRAIN: if (n >= dstart + G && window_stable(n)) begin
                act = v;
                mode = (v != 0) ? M_ACT : M_OFF;
            end
            default: if (v != act && !lk) begin mode = M_DRAIN; dstart = n; end
        endcase
        if (prev == M_ACT && mode == M_ACT) begin
            e_out = slice(dg_out, act);
            e_oeb = slice(dg_oeb, act);
        end else begin
            e_out = '0;
            e_oeb = '1;
        end
        e_ncs = '1;
        if (mode == M_ACT) e_ncs[act-1] = 1'b0;
    endtask

    task automatic tick();
        for (int i = 0; i < N*GW; i++) begin
            dg_out[i] = 1'($urandom);
            dg_oeb[i] = 1'($urandom);
        end
        @(posedge clk);
        n++;
        selh[n] = int'(design_select);
        model_step();
        #1;
        check("ncs", 64'(designs_ncs), 64'(e_ncs));
        check("gpio_out", 64'(gpio_out), 64'(e_out));
        check("gpio_oeb", 64'(gpio_oeb), 64'(e_oeb));
        check("active", 64'(active_design), 64'(act));
        check("switching", 64'(switching), 64'(mode == M_DRAIN));
        check("one_ncs_low", 64'($countones(~designs_ncs) <= 1), 64'(1));
    endtask

    task automatic wait_active(input int code);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            tick();
            if (int'(active_design) == code && designs_ncs != '1) hit = 1'b1;
        end
        check("wait_active", 64'(hit), 64'(1));
    endtask

    initial begin
        int seen;
        int bad_oeb;
        int k;
        bit got;

        // Reset values while rst is held
        repeat (2) @(negedge clk);
        check("rst_ncs", 64'(designs_ncs), 64'(12'hFFF));
        check("rst_oeb", 64'(gpio_oeb), 64'({GW{1'b1}}));
        check("rst_out", 64'(gpio_out), 64'(0));
        rst = 1'b0;
        model_reset();

        // Select 1 from OFF: ncs falls on edge S+1+G
        design_select = 4'd1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i < 7) check("lat_ncs_wait", 64'(designs_ncs), 64'(12'hFFF));
            if (i >= 3 && i <= 6) check("lat_switching", 64'(switching), 64'(1));
        end
        check("lat_ncs", 64'(designs_ncs), 64'(12'hFFE));
        check("lat_first_oeb", 64'(gpio_oeb), 64'({GW{1'b1}}));
        tick();
        check("lat_pad_data", 64'(gpio_out), 64'(dg_out[GW-1:0]));

        // Switch 3 -> 5
        design_select = 4'd3;
        wait_active(3);
        design_select = 4'd5;
        seen = 0; bad_oeb = 0; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (designs_ncs == 12'hFFF) begin
                seen++;
                if (gpio_oeb != {GW{1'b1}}) bad_oeb++;
            end else if (designs_ncs == 12'hFEF) begin
                got = 1'b1;
            end
        end
        check("sw35_guard_len", 64'(seen), 64'(4));
        check("sw35_guard_oeb", 64'(bad_oeb), 64'(0));
        check("sw35_ncs", 64'(got), 64'(1));

        // Invalid codes while design 2 is active
        design_select = 4'd2;
        wait_active(2);
        design_select = 4'd13;
        repeat (2) tick();
        design_select = 4'd15;
        repeat (12) tick();
        check("inv_active", 64'(active_design), 64'(0));
        check("inv_ncs", 64'(designs_ncs), 64'(12'hFFF));
        check("inv_oeb", 64'(gpio_oeb), 64'({GW{1'b1}}));
        check("inv_switching", 64'(switching), 64'(0));

        // Glitching select during DRAIN
        design_select = 4'd1;
        repeat (3) tick();
        check("gl_in_drain", 64'(switching), 64'(1));
        design_select = 4'd2;
        tick();
        design_select = 4'd1;
        tick();
        k = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            k++;
            if (designs_ncs != 12'hFFF) got = 1'b1;
        end
        check("gl_delay", 64'(k), 64'(6));
        check("gl_active", 64'(active_design), 64'(1));

        // Asynchronous reset mid-cycle while design 4 is active
        design_select = 4'd4;
        wait_active(4);
        #2 rst = 1'b1;
        #1;
        check("arst_ncs", 64'(designs_ncs), 64'(12'hFFF));
        check("arst_oeb", 64'(gpio_oeb), 64'({GW{1'b1}}));
        check("arst_out", 64'(gpio_out), 64'(0));
        check("arst_active", 64'(active_design), 64'(0));
        check("arst_switching", 64'(switching), 64'(0));
        #1 rst = 1'b0;
        model_reset();

`ifdef DESIGN_SEL_LOCK_EN
        // Lock holds design 4 against a new request
        design_select = 4'd4;
        wait_active(4);
        sel_lock = 1'b1;
        design_select = 4'd6;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("lock_hold", 64'(designs_ncs), 64'(12'hFF7));
        end
        sel_lock = 1'b0;
        tick();
        check("lock_release_drain", 64'(switching), 64'(1));
        repeat (4) tick();
        check("lock_new_ncs", 64'(designs_ncs), 64'(12'hFDF));
`endif

        // Random select traffic
        for (int r = 0; r < 250; r++) begin
            design_select = SW'($urandom_range(0, 15));
            sel_lock = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 10)) tick();
        end
        sel_lock = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
